// File: rtl/led_out_pkg.sv
// Shared types and default sizing for the LED shift-register output stage.
package led_out_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StLatch
   } led_state_e;

   localparam int unsigned LED_FRAME_W  = 26;
   localparam int unsigned LED_SCLK_DIV = 6;

endpackage

// File: rtl/half_period_tick.sv
// Free-running divider that pulses tick_o every DIV clocks; clr_i restarts the count so the
// first half-period of a frame is full length.
module half_period_tick #(
   parameter int unsigned DIV = 6
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = $clog2(DIV) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || (cnt_q == CntMax)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/led_shift_out.sv
// Serialises one LED frame into a 74HC595-style chain: DATA_W sclk pulses, then one latch pulse,
// then a one-cycle done pulse. All pin outputs come straight from registers.
module led_shift_out
   import led_out_pkg::*;
#(
   parameter int unsigned DATA_W    = LED_FRAME_W,
   parameter int unsigned CLK_DIV   = LED_SCLK_DIV,
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              load_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy_out,
   output logic              done_pulse_out,
   output logic              sclk_out,
   output logic              sdata_out,
   output logic              latch_out
);

   localparam int unsigned BitW = $clog2(DATA_W) + 1;
   localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

   led_state_e        state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] shifted;
   logic [BitW-1:0]   bit_q, bit_d;
   logic              sclk_q, sclk_d;
   logic              sdata_q, sdata_d;
   logic              latch_q, latch_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              tick_clr;
   logic              tick;

   half_period_tick #(
      .DIV(CLK_DIV)
   ) u_tick (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .clr_i (tick_clr),
      .tick_o(tick)
   );

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bit_d    = bit_q;
      sclk_d   = sclk_q;
      sdata_d  = sdata_q;
      latch_d  = latch_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      tick_clr = 1'b0;
      shifted  = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

      unique case (state_q)
         StIdle: begin
            sclk_d  = 1'b0;
            latch_d = 1'b0;
            busy_d  = 1'b0;
            if (load_in) begin
               tick_clr = 1'b1;
               shreg_d  = data_in;
               bit_d    = '0;
               sdata_d  = LSB_FIRST ? data_in[0] : data_in[DATA_W-1];
               busy_d   = 1'b1;
               state_d  = StShift;
            end
         end
         StShift: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // Data only moves on the falling sclk edge, giving CLK_DIV setup and hold.
                  sclk_d = 1'b0;
                  if (bit_q == BitLast) begin
                     latch_d = 1'b1;
                     state_d = StLatch;
                  end else begin
                     bit_d   = bit_q + 1'b1;
                     shreg_d = shifted;
                     sdata_d = LSB_FIRST ? shifted[0] : shifted[DATA_W-1];
                  end
               end
            end
         end
         StLatch: begin
            if (tick) begin
               latch_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= StIdle;
         shreg_q <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         sdata_q <= 1'b0;
         latch_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         sdata_q <= sdata_d;
         latch_q <= latch_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_out       = busy_q;
   assign done_pulse_out = done_q;
   assign sclk_out       = sclk_q;
   assign sdata_out      = sdata_q;
   assign latch_out      = latch_q;

endmodule

// File: tb/tb_led_shift_out.sv
// Randomised scoreboard bench: stimulus queues the expected serial bit order of each frame, and a
// negedge monitor rebuilds frames from the pins and checks timing, order and handshakes.
module tb_led_shift_out;

   localparam int unsigned W1 = 26;
   localparam int unsigned D1 = 6;
   localparam int unsigned W2 = 8;
   localparam int unsigned D2 = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          load1 = 1'b0;
   logic [W1-1:0] data1 = '0;
   logic          busy1, done1, sclk1, sdata1, latch1;
   logic          load2 = 1'b0;
   logic [W2-1:0] data2 = '0;
   logic          busy2, done2, sclk2, sdata2, latch2;

   led_shift_out #(
      .DATA_W   (W1),
      .CLK_DIV  (D1),
      .LSB_FIRST(1'b0)
   ) u_dut1 (
      .clk_in        (clk),
      .rst_in        (rst),
      .load_in       (load1),
      .data_in       (data1),
      .busy_out      (busy1),
      .done_pulse_out(done1),
      .sclk_out      (sclk1),
      .sdata_out     (sdata1),
      .latch_out     (latch1)
   );

   led_shift_out #(
      .DATA_W   (W2),
      .CLK_DIV  (D2),
      .LSB_FIRST(1'b1)
   ) u_dut2 (
      .clk_in        (clk),
      .rst_in        (rst),
      .load_in       (load2),
      .data_in       (data2),
      .busy_out      (busy2),
      .done_pulse_out(done2),
      .sclk_out      (sclk2),
      .sdata_out     (sdata2),
      .latch_out     (latch2)
   );

   logic [63:0] q1[$];
   logic [63:0] q2[$];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  timeouts = 0;
   bit  stim_done = 1'b0;

   // Reference: bit k of the result is the k-th bit to appear on the serial line.
   function automatic logic [63:0] order_bits(input logic [63:0] d, input int w, input bit lsb);
      logic [63:0] o;
      o = '0;
      for (int i = 0; i < w; i++) o[i] = lsb ? d[i] : d[w-1-i];
      return o;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------------------------------------------------------- monitor
   int          cyc = 0;
   bit          armed = 1'b0;
   logic        p_busy1 = 0, p_done1 = 0, p_sclk1 = 0, p_sdata1 = 0, p_latch1 = 0;
   logic        p_busy2 = 0, p_sclk2 = 0, p_sdata2 = 0;
   int          nrise1 = 0, blen1 = 0, run1 = 0, llen1 = 0, nlatch1 = 0, glitch1 = 0;
   int          last_done1 = -100, n_b2b = 0, ndone1 = 0;
   bit          b2b1 = 1'b0;
   logic [63:0] obs1 = '0;
   int          nrise2 = 0, blen2 = 0, tog2 = 0, glitch2 = 0, ndone2 = 0;
   logic [63:0] obs2 = '0;
   logic [63:0] exp_v;

   always @(negedge clk) begin
      cyc++;
      if (cyc > 60000) begin
         $display("FAIL watchdog: cycle %0d reached, limit 60000", cyc);
         $fatal(1);
      end
      if (rst) armed = 1'b1;
      if (armed && rst) begin
         check("reset_outputs", 64'({busy1, done1, sclk1, sdata1, latch1,
                                     busy2, done2, sclk2, sdata2, latch2}), 64'd0);
         q1.delete();
         q2.delete();
         nrise1 = 0; glitch1 = 0; nlatch1 = 0;
         nrise2 = 0; glitch2 = 0;
      end else if (armed) begin
         // DUT1: defaults, MSB first
         if (busy1 && !p_busy1) begin
            check("frame_expected1", 64'(q1.size() > 0), 64'd1);
            nrise1 = 0; obs1 = '0; blen1 = 0; run1 = 0; nlatch1 = 0;
            b2b1 = (cyc - last_done1 == 1);
         end
         if (sdata1 !== p_sdata1 && !(p_sclk1 && !sclk1) && !(busy1 && !p_busy1)) glitch1++;
         if (busy1) blen1++;
         if (busy1 && !latch1) begin
            if (sclk1 != p_sclk1) begin
               check(sclk1 ? "low_phase1" : "high_phase1", 64'(run1), 64'(D1));
               run1 = 1;
            end else begin
               run1++;
            end
         end
         if (sclk1 && !p_sclk1) begin
            check("sclk_latch_excl1", 64'(latch1), 64'd0);
            obs1[nrise1] = sdata1;
            nrise1++;
         end
         if (latch1 && !p_latch1) begin
            check("latch_after_bits1", 64'(nrise1), 64'(W1));
            check("latch_sclk_excl1", 64'(sclk1), 64'd0);
            llen1 = 1;
            nlatch1++;
         end else if (latch1) begin
            llen1++;
         end
         if (!latch1 && p_latch1) check("latch_len1", 64'(llen1), 64'(D1));
         if (!busy1 && p_busy1) begin
            check("busy_len1", 64'(blen1), 64'(2 * D1 * W1 + D1));
            check("done_at_busy_fall1", 64'(done1), 64'd1);
         end
         if (p_done1) check("done_width1", 64'(done1), 64'd0);
         if (done1) begin
            ndone1++;
            check("done_expected1", 64'(q1.size() > 0), 64'd1);
            if (q1.size() > 0) begin
               exp_v = q1.pop_front();
               check("frame_bits1", obs1, exp_v);
               check("nbits1", 64'(nrise1), 64'(W1));
               check("nlatch1", 64'(nlatch1), 64'd1);
               check("sdata_stable1", 64'(glitch1), 64'd0);
            end
            if (b2b1) begin
               n_b2b++;
               check("b2b_period1", 64'(cyc - last_done1), 64'(2 * D1 * W1 + D1 + 1));
            end
            last_done1 = cyc;
            nrise1 = 0; glitch1 = 0; b2b1 = 1'b0;
         end

         // DUT2: corner parameters, LSB first, sclk toggling every cycle
         if (busy2 && !p_busy2) begin
            check("frame_expected2", 64'(q2.size() > 0), 64'd1);
            nrise2 = 0; obs2 = '0; blen2 = 0; tog2 = 0;
         end
         if (sdata2 !== p_sdata2 && !(p_sclk2 && !sclk2) && !(busy2 && !p_busy2)) glitch2++;
         if (busy2) blen2++;
         if (busy2 && p_busy2 && !latch2 && (sclk2 == p_sclk2)) tog2++;
         if (sclk2 && !p_sclk2) begin
            obs2[nrise2] = sdata2;
            nrise2++;
         end
         if (done2) begin
            ndone2++;
            check("done_expected2", 64'(q2.size() > 0), 64'd1);
            if (q2.size() > 0) begin
               exp_v = q2.pop_front();
               check("frame_bits2", obs2, exp_v);
               check("nbits2", 64'(nrise2), 64'(W2));
               check("busy_len2", 64'(blen2), 64'(2 * D2 * W2 + D2));
               check("sclk_toggle2", 64'(tog2), 64'd0);
               check("sdata_stable2", 64'(glitch2), 64'd0);
            end
            nrise2 = 0; glitch2 = 0;
         end
      end
      p_busy1 = busy1; p_done1 = done1; p_sclk1 = sclk1; p_sdata1 = sdata1; p_latch1 = latch1;
      p_busy2 = busy2; p_sclk2 = sclk2; p_sdata2 = sdata2;

      if (stim_done) begin
         check("timeouts", 64'(timeouts), 64'd0);
         check("queue1_empty", 64'(q1.size()), 64'd0);
         check("queue2_empty", 64'(q2.size()), 64'd0);
         check("b2b_count", 64'(n_b2b), 64'd3);
         check("frames1", 64'(ndone1), 64'd10);
         check("frames2", 64'(ndone2), 64'd2);
         $display("%0d/%0d checks passed", n_pass, n_checks);
         $finish;
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic wait_done1(input int bound);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk);
         seen = done1;
      end
      if (!seen) timeouts++;
   endtask

   task automatic wait_done2(input int bound);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk);
         seen = done2;
      end
      if (!seen) timeouts++;
   endtask

   task automatic wait_rise1(input int n, input int bound);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk);
         seen = (nrise1 >= n);
      end
      if (!seen) timeouts++;
   endtask

   task automatic send1(input logic [W1-1:0] d);
      logic [31:0] r;
      data1 = d;
      q1.push_back(order_bits(64'(d), W1, 1'b0));
      load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
      r = $urandom;
      data1 = r[W1-1:0];
   endtask

   initial begin
      logic [31:0] r;
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);

      send1(26'h2AAAAAA);
      wait_done1(400);

      // Loads mid-frame must be ignored
      @(negedge clk);
      r = $urandom;
      send1(r[W1-1:0]);
      wait_rise1(5, 200);
      load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
      wait_rise1(20, 400);
      data1 = ~data1;
      load1 = 1'b1;
      @(negedge clk);
      load1 = 1'b0;
      wait_done1(400);
      repeat (330) @(negedge clk);

      for (int i = 0; i < 3; i++) begin
         r = $urandom;
         send1(r[W1-1:0]);
         wait_done1(400);
         repeat ($urandom_range(1, 4)) @(negedge clk);
      end

      // Held load: four frames, each done cycle accepting the next
      data1 = 26'h3FFFFFF;
      repeat (4) q1.push_back(order_bits(64'(data1), W1, 1'b0));
      load1 = 1'b1;
      repeat (3) wait_done1(400);
      @(negedge clk);
      load1 = 1'b0;
      wait_done1(400);
      repeat (2) @(negedge clk);

      // Abort mid-frame, then a clean frame
      r = $urandom;
      send1(r[W1-1:0]);
      wait_rise1(10, 400);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (400) @(negedge clk);
      send1(26'h1234567);
      wait_done1(400);

      // Corner instance
      repeat (2) @(negedge clk);
      data2 = 8'h01;
      q2.push_back(order_bits(64'(data2), W2, 1'b1));
      load2 = 1'b1;
      @(negedge clk);
      load2 = 1'b0;
      wait_done2(50);
      repeat (2) @(negedge clk);
      r = $urandom;
      data2 = r[W2-1:0];
      q2.push_back(order_bits(64'(data2), W2, 1'b1));
      load2 = 1'b1;
      @(negedge clk);
      load2 = 1'b0;
      wait_done2(50);
      repeat (3) @(negedge clk);
      stim_done = 1'b1;
   end

endmodule

// File: doc/led_shift_out.md
Name: led_shift_out

Overview:
- Downstream output stage for the board-test top level.
- Serialises the packed LED image {Water_led, Segment_led_2, Segment_led_1} into a 74HC595-style shift-register chain on three GPIO pins: serial clock, serial data and storage latch.
- One frame is one load request. Each frame produces DATA_W sclk pulses followed by one latch pulse.
- A done pulse lets the upstream refresh logic issue the next frame.

Parameters:
- DATA_W, 26: frame width in bits (8 water + 9 + 9 segment); minimum 1.
- CLK_DIV, 6: clk_in cycles per sclk half-period; minimum 1 (6 at 12 MHz gives sclk = 1 MHz).
- LSB_FIRST, 0: 0 shifts data_in[DATA_W-1] first; 1 shifts data_in[0] first.

Ports:
- clk_in  input  1  system clock, 12 MHz.
- rst_in  input  1  reset; one clock; asynchronous, active-high.
- load_in  input  1  frame request; sampled on rising clk_in.
- data_in  input  DATA_W  frame data; captured only on an accepted load.
- busy_out  output  1  high while a frame is in progress.
- done_pulse_out  output  1  one-cycle pulse when a frame completes.
- sclk_out  output  1  shift clock to the chain; data is sampled by the chain on its rising edge.
- sdata_out  output  1  serial data.
- latch_out  output  1  storage-register latch, active-high.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - State = IDLE; shift register and all counters cleared.
  - All outputs are 0.
  - No latch pulse and no done pulse is emitted for an aborted frame.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - sclk_out=0, latch_out=0, busy_out=0.
  - If load_in=1 on a clock edge: capture data_in into the shift register, clear the divider and bit counters, go to SHIFT.
- SHIFT:
  - busy_out=1 from the cycle after acceptance.
  - Each bit uses CLK_DIV cycles with sclk_out=0, then CLK_DIV cycles with sclk_out=1.
  - sdata_out presents the current bit for the whole low and high phase of that bit.
  - sdata_out changes only on the same edge where sclk_out falls (or on entry to SHIFT). This gives a setup time of CLK_DIV cycles and a hold time of CLK_DIV cycles.
  - Bit order follows LSB_FIRST.
  - After the high phase of bit DATA_W-1 ends: sclk_out falls, go to LATCH.
- LATCH:
  - latch_out=1 for exactly CLK_DIV cycles.
  - sdata_out holds the last bit; sclk_out=0.
  - Then go to IDLE.
- Completion:
  - On the first IDLE cycle after LATCH: done_pulse_out=1 for one cycle and busy_out=0 in that same cycle.
  - busy_out is high for exactly 2*CLK_DIV*DATA_W + CLK_DIV cycles per frame.
- Request handling:
  - load_in while busy: ignored, not queued.
  - data_in changes while busy: no effect.
  - load_in=1 in the done cycle is accepted. A held-high load_in therefore gives continuous frames separated by one idle cycle.
- Width rules:
  - Divider counter: $clog2(CLK_DIV)+1 bits; wraps at CLK_DIV-1.
  - Bit counter: $clog2(DATA_W)+1 bits.
  - No counter may overflow for any legal parameter value.
- Glitch rules:
  - All outputs are registered; no combinational paths from inputs to outputs.
  - sclk_out and latch_out are never high in the same cycle.

Decomposition:
- Shared package led_out_pkg:
  - state enum (IDLE, SHIFT, LATCH);
  - default constants LED_FRAME_W=26 and LED_SCLK_DIV=6.
- One natural sub-module, half_period_tick:
  - counts to CLK_DIV-1 and emits a one-cycle tick;
  - cleared synchronously by the FSM on frame start;
  - the FSM uses each tick to toggle sclk_out and advance bits and the latch phase.

Test Plan:
- Reset: assert rst_in mid-cycle with clocks running -> all outputs 0 before the next clk_in edge; stay 0 while held.
- Single frame, defaults: load_in pulse with data_in=26'h2AAAAAA.
  - Exactly 26 sclk rising edges, sampled bits 1,0,1,0,… MSB first.
  - sclk high and low phases each 6 cycles.
  - latch_out high 6 cycles after the last sclk falls.
  - busy_out high 318 cycles; done_pulse_out 1 cycle.
- Busy protection: pulse load_in with a different data_in at bit 5 and again at bit 20 -> frame content unchanged, no second frame.
- Back-to-back: hold load_in=1 with data_in=26'h3FFFFFF -> each done cycle immediately followed by a new frame; period 319 cycles.
- Abort: rst_in pulse after the 10th sclk rising edge -> latch_out never asserts, no done pulse; the next load sends a clean full frame.
- Parameter corner: DATA_W=8, CLK_DIV=1, LSB_FIRST=1, data_in=8'h01 -> first sampled bit 1 then seven 0s; sclk toggles every cycle; busy_out high 17 cycles.
